// File: rtl/alu_sequencer.sv
// Single-issue sequencer for the 8-bit ALU: IDLE -> READ -> EXEC -> WRITE, with an 8x8 register file and flags.
// Optional feature macro ALU_SEQ_SHOW_EN enables the SHOWR (11111) register-display opcode.
module alu_sequencer #(
  parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [4:0] instr_op,
  input  logic [2:0] instr_rd,
  input  logic [2:0] instr_rs,
  input  logic [2:0] instr_im,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [2:0] alu_im,
  output logic [4:0] alu_op,
  input  logic [7:0] alu_res,
  input  logic       alu_cf,
  input  logic       alu_zf,
  input  logic       alu_sf,
  input  logic       alu_of,
  output logic [3:0] flags,
  output logic       done,
  output logic       err,
  output logic [7:0] show_data,
  output logic       show_valid
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_EXEC = 2'd2, ST_WRITE = 2'd3} state_t;
  typedef enum logic [1:0] {CLS_WRF = 2'd0, CLS_WR = 2'd1, CLS_NOWR = 2'd2, CLS_ILL = 2'd3} op_class_t;

  function automatic op_class_t classify(input logic [4:0] op);
    case (op)
      5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
      5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110: classify = CLS_WRF;
      5'b00110, 5'b01000: classify = CLS_WR;
      5'b00000: classify = CLS_NOWR;
`ifdef ALU_SEQ_SHOW_EN
      5'b11111: classify = CLS_NOWR;
`endif
      default: classify = CLS_ILL;
    endcase
  endfunction

  state_t      state_r, state_s;
  op_class_t   cls_s;
  logic [4:0]  op_r;
  logic [2:0]  rd_r, rs_r, im_r;
  logic        ready_r, ready_s;
  logic [7:0]  in1_r, in1_s, in2_r, in2_s;
  logic [2:0]  alu_im_r, alu_im_s;
  logic [4:0]  alu_op_r, alu_op_s;
  logic [7:0]  res_r, res_s;
  logic [3:0]  cap_r, cap_s;
  logic [3:0]  flags_r, flags_s;
  logic        done_r, done_s, err_r, err_s;
  logic        accept_s, wr_en_s;
  logic [7:0]  rf_r [8];
`ifdef ALU_SEQ_SHOW_EN
  logic [7:0]  show_data_r, show_data_s;
  logic        show_valid_r, show_valid_s;
`endif

  assign cls_s = classify(op_r);

  // Next-state and next registered-output values
  always_comb begin
    state_s  = state_r;
    ready_s  = ready_r;
    in1_s    = in1_r;
    in2_s    = in2_r;
    alu_im_s = alu_im_r;
    alu_op_s = alu_op_r;
    res_s    = res_r;
    cap_s    = cap_r;
    flags_s  = flags_r;
    done_s   = done_r;
    err_s    = err_r;
    accept_s = 1'b0;
    wr_en_s  = 1'b0;
`ifdef ALU_SEQ_SHOW_EN
    show_data_s  = show_data_r;
    show_valid_s = show_valid_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (instr_valid && ready_r) begin
          accept_s = 1'b1;
          ready_s  = 1'b0;
          state_s  = ST_READ;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_READ: begin
        in1_s    = rf_r[rd_r];
        in2_s    = rf_r[rs_r];
        alu_im_s = im_r;
        // Illegal opcodes never reach the ALU
        alu_op_s = (cls_s == CLS_ILL) ? 5'b00000 : op_r;
        state_s  = ST_EXEC;
      end
      ST_EXEC: begin
        res_s   = alu_res;
        cap_s   = {alu_cf, alu_zf, alu_sf, alu_of};
        done_s  = 1'b1;
        err_s   = (cls_s == CLS_ILL);
`ifdef ALU_SEQ_SHOW_EN
        if (op_r == 5'b11111) begin
          show_data_s  = alu_res;
          show_valid_s = 1'b1;
        end else begin
          show_valid_s = 1'b0;
        end
`endif
        state_s = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en_s  = (cls_s == CLS_WRF) || (cls_s == CLS_WR);
        flags_s  = (cls_s == CLS_WRF) ? cap_r : flags_r;
        done_s   = 1'b0;
        err_s    = 1'b0;
        alu_op_s = 5'b00000;
        ready_s  = 1'b1;
`ifdef ALU_SEQ_SHOW_EN
        show_valid_s = 1'b0;
`endif
        state_s  = ST_IDLE;
      end
      default: begin
        state_s  = ST_IDLE;
        ready_s  = 1'b1;
        alu_op_s = 5'b00000;
        done_s   = 1'b0;
        err_s    = 1'b0;
      end
    endcase
  end

  // FSM state, latched instruction fields and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      op_r     <= 5'b00000;
      rd_r     <= 3'd0;
      rs_r     <= 3'd0;
      im_r     <= 3'd0;
      ready_r  <= 1'b1;
      in1_r    <= 8'h00;
      in2_r    <= 8'h00;
      alu_im_r <= 3'd0;
      alu_op_r <= 5'b00000;
      res_r    <= 8'h00;
      cap_r    <= 4'b0000;
      flags_r  <= 4'b0000;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
`ifdef ALU_SEQ_SHOW_EN
      show_data_r  <= 8'h00;
      show_valid_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      ready_r  <= ready_s;
      in1_r    <= in1_s;
      in2_r    <= in2_s;
      alu_im_r <= alu_im_s;
      alu_op_r <= alu_op_s;
      res_r    <= res_s;
      cap_r    <= cap_s;
      flags_r  <= flags_s;
      done_r   <= done_s;
      err_r    <= err_s;
`ifdef ALU_SEQ_SHOW_EN
      show_data_r  <= show_data_s;
      show_valid_r <= show_valid_s;
`endif
      if (accept_s) begin
        op_r <= instr_op;
        rd_r <= instr_rd;
        rs_r <= instr_rs;
        im_r <= instr_im;
      end
    end
  end

  // Register file; writeback lands on the WRITE exit edge so the next READ sees it
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        rf_r[i] <= REG_RESET_VAL;
      end
    end else if (wr_en_s) begin
      rf_r[rd_r] <= res_r;
    end
  end

  assign instr_ready = ready_r;
  assign alu_in1     = in1_r;
  assign alu_in2     = in2_r;
  assign alu_im      = alu_im_r;
  assign alu_op      = alu_op_r;
  assign flags       = flags_r;
  assign done        = done_r;
  assign err         = err_r;
`ifdef ALU_SEQ_SHOW_EN
  assign show_data   = show_data_r;
  assign show_valid  = show_valid_r;
`else
  assign show_data   = 8'h00;
  assign show_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a small behavioural ALU model.
module tb_alu_sequencer;

  logic       clock;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [4:0] instr_op;
  logic [2:0] instr_rd, instr_rs, instr_im;
  logic [7:0] alu_in1, alu_in2;
  logic [2:0] alu_im;
  logic [4:0] alu_op;
  logic [7:0] alu_res;
  logic       alu_cf, alu_zf, alu_sf, alu_of;
  logic [3:0] flags;
  logic       done, err;
  logic [7:0] show_data;
  logic       show_valid;

  int check_cnt = 0;
  int err_cnt   = 0;

  logic       c1_ready, c1_done, c2_ready, c3_done, c3_err, c3_ready, c3_sv, c4_ready, c4_done, c4_sv;
  logic [7:0] c2_in1, c2_in2, c3_sd, c4_sd;
  logic [2:0] c2_im;
  logic [4:0] c2_op, c4_op;
  logic [3:0] c4_flags;

  alu_sequencer #(.REG_RESET_VAL(8'h05)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_im(instr_im),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_im(alu_im), .alu_op(alu_op),
    .alu_res(alu_res), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .flags(flags), .done(done), .err(err),
    .show_data(show_data), .show_valid(show_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: ADD 00001, AND 00010, SUB 00011, OR 00100, XOR 00101, MOV 00110,
  // NOT 01000, SHL 01001, SHR 01010, SAR 01011, SHOWR 11111
  always_comb begin
    alu_res = 8'h00;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (alu_op)
      5'b00001: begin
        {alu_cf, alu_res} = {1'b0, alu_in1} + {1'b0, alu_in2};
        alu_of = (alu_in1[7] == alu_in2[7]) && (alu_res[7] != alu_in1[7]);
      end
      5'b00010: alu_res = alu_in1 & alu_in2;
      5'b00011: begin
        {alu_cf, alu_res} = {1'b0, alu_in1} - {1'b0, alu_in2};
        alu_of = (alu_in1[7] != alu_in2[7]) && (alu_res[7] != alu_in1[7]);
      end
      5'b00100: alu_res = alu_in1 | alu_in2;
      5'b00101: alu_res = alu_in1 ^ alu_in2;
      5'b00110: alu_res = alu_in2;
      5'b01000: alu_res = ~alu_in1;
      5'b01001: {alu_cf, alu_res} = {1'b0, alu_in1} << alu_im;
      5'b01010: {alu_res, alu_cf} = {alu_in1, 1'b0} >> alu_im;
      5'b01011: {alu_res, alu_cf} = $signed({alu_in1, 1'b0}) >>> alu_im;
      5'b11111: alu_res = alu_in1;
      default:  alu_res = 8'h00;
    endcase
    alu_zf = (alu_op != 5'b00000) && (alu_res == 8'h00);
    alu_sf = alu_res[7];
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one instruction from a negedge with the sequencer idle; samples cycles 1..4 at negedges
  task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] im, input bit hold);
    check_val("pre_ready", {15'd0, instr_ready}, 16'd1);
    instr_valid = 1'b1;
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_im = im;
    @(posedge clock);
    #1;
    if (!hold) instr_valid = 1'b0;
    @(negedge clock);
    c1_ready = instr_ready; c1_done = done;
    @(negedge clock);
    c2_in1 = alu_in1; c2_in2 = alu_in2; c2_op = alu_op; c2_im = alu_im; c2_ready = instr_ready;
    @(negedge clock);
    c3_done = done; c3_err = err; c3_ready = instr_ready; c3_sv = show_valid; c3_sd = show_data;
    @(negedge clock);
    c4_ready = instr_ready; c4_done = done; c4_op = alu_op; c4_flags = flags;
    c4_sv = show_valid; c4_sd = show_data;
  endtask

  task automatic check_txn(input string tag, input logic [7:0] e_in1, input logic [7:0] e_in2,
                           input logic [4:0] e_op, input logic e_err, input logic [3:0] e_flags);
    check_val({tag, ".ready_c1"}, {15'd0, c1_ready}, 16'd0);
    check_val({tag, ".done_c1"},  {15'd0, c1_done},  16'd0);
    check_val({tag, ".in1"},      {8'd0, c2_in1},    {8'd0, e_in1});
    check_val({tag, ".in2"},      {8'd0, c2_in2},    {8'd0, e_in2});
    check_val({tag, ".alu_op"},   {11'd0, c2_op},    {11'd0, e_op});
    check_val({tag, ".ready_c2"}, {15'd0, c2_ready}, 16'd0);
    check_val({tag, ".done_c3"},  {15'd0, c3_done},  16'd1);
    check_val({tag, ".err_c3"},   {15'd0, c3_err},   {15'd0, e_err});
    check_val({tag, ".ready_c3"}, {15'd0, c3_ready}, 16'd0);
    check_val({tag, ".ready_c4"}, {15'd0, c4_ready}, 16'd1);
    check_val({tag, ".done_c4"},  {15'd0, c4_done},  16'd0);
    check_val({tag, ".op_c4"},    {11'd0, c4_op},    16'd0);
    check_val({tag, ".flags_c4"}, {12'd0, c4_flags}, {12'd0, e_flags});
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0;
    instr_op = 5'b00000; instr_rd = 3'd0; instr_rs = 3'd0; instr_im = 3'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_val("rst.ready", {15'd0, instr_ready}, 16'd1);
    check_val("rst.alu_op", {11'd0, alu_op}, 16'd0);
    check_val("rst.in1", {8'd0, alu_in1}, 16'd0);
    check_val("rst.in2", {8'd0, alu_in2}, 16'd0);
    check_val("rst.im", {13'd0, alu_im}, 16'd0);
    check_val("rst.flags", {12'd0, flags}, 16'd0);
    check_val("rst.done", {15'd0, done}, 16'd0);
    check_val("rst.err", {15'd0, err}, 16'd0);
    check_val("rst.show", {7'd0, show_valid, show_data}, 16'd0);

    issue(5'b00001, 3'd1, 3'd2, 3'd0, 1'b0);   // R1 = 05+05 = 0A
    check_txn("add_basic", 8'h05, 8'h05, 5'b00001, 1'b0, 4'b0000);
    issue(5'b01000, 3'd3, 3'd0, 3'd0, 1'b0);   // R3 = ~05 = FA
    check_txn("not_r3", 8'h05, 8'h05, 5'b01000, 1'b0, 4'b0000);
    issue(5'b00001, 3'd3, 3'd2, 3'd0, 1'b0);   // R3 = FA+05 = FF
    check_txn("add_ff", 8'hFA, 8'h05, 5'b00001, 1'b0, 4'b0010);
    issue(5'b01010, 3'd6, 3'd6, 3'd2, 1'b0);   // R6 = 05>>2 = 01
    check_txn("shr_r6", 8'h05, 8'h05, 5'b01010, 1'b0, 4'b0000);
    check_val("shr_r6.im", {13'd0, c2_im}, 16'd2);
    issue(5'b00001, 3'd3, 3'd6, 3'd0, 1'b0);   // R3 = FF+01 = 00, carry+zero
    check_txn("add_carry", 8'hFF, 8'h01, 5'b00001, 1'b0, 4'b1100);
    issue(5'b00110, 3'd3, 3'd6, 3'd0, 1'b0);   // R3 = R6 = 01, flags kept
    check_txn("mov_r3", 8'h00, 8'h01, 5'b00110, 1'b0, 4'b1100);
    issue(5'b01001, 3'd3, 3'd3, 3'd7, 1'b0);   // R3 = 01<<7 = 80
    check_txn("shl_r3", 8'h01, 8'h01, 5'b01001, 1'b0, 4'b0010);
    issue(5'b00001, 3'd3, 3'd6, 3'd0, 1'b0);   // R3 = 80+01 = 81
    check_txn("add_81", 8'h80, 8'h01, 5'b00001, 1'b0, 4'b0010);
    issue(5'b01011, 3'd3, 3'd3, 3'd1, 1'b0);   // R3 = sar(81,1) = C0, CF SF
    check_txn("sar_r3", 8'h81, 8'h81, 5'b01011, 1'b0, 4'b1010);
    issue(5'b01000, 3'd3, 3'd3, 3'd0, 1'b0);   // R3 = ~C0 = 3F, flags kept
    check_txn("not_c0", 8'hC0, 8'hC0, 5'b01000, 1'b0, 4'b1010);

    issue(5'b10101, 3'd1, 3'd3, 3'd0, 1'b1);   // illegal, valid held through WRITE
    check_txn("ill_1", 8'h0A, 8'h3F, 5'b00000, 1'b1, 4'b1010);
    issue(5'b10101, 3'd1, 3'd3, 3'd0, 1'b0);   // re-accepted in cycle 4
    check_txn("ill_2", 8'h0A, 8'h3F, 5'b00000, 1'b1, 4'b1010);
    repeat (2) begin
      @(negedge clock);
      check_val("idle.ready", {15'd0, instr_ready}, 16'd1);
      check_val("idle.done", {15'd0, done}, 16'd0);
    end

    issue(5'b01001, 3'd5, 3'd5, 3'd4, 1'b0);   // R5 = 05<<4 = 50
    check_txn("shl_r5", 8'h05, 8'h05, 5'b01001, 1'b0, 4'b0000);
    issue(5'b00001, 3'd5, 3'd1, 3'd0, 1'b0);   // R5 = 50+0A = 5A
    check_txn("add_5a", 8'h50, 8'h0A, 5'b00001, 1'b0, 4'b0000);
    issue(5'b00001, 3'd1, 3'd1, 3'd0, 1'b0);   // rd==rs: R1 = 0A+0A
    check_txn("add_same", 8'h0A, 8'h0A, 5'b00001, 1'b0, 4'b0000);
    issue(5'b00110, 3'd0, 3'd1, 3'd0, 1'b0);   // R0 = R1, confirms 14
    check_txn("mov_r0", 8'h05, 8'h14, 5'b00110, 1'b0, 4'b0000);

    issue(5'b11111, 3'd5, 3'd5, 3'd0, 1'b0);
`ifdef ALU_SEQ_SHOW_EN
    check_txn("showr", 8'h5A, 8'h5A, 5'b11111, 1'b0, 4'b0000);
    check_val("showr.sv_c3", {15'd0, c3_sv}, 16'd1);
    check_val("showr.sd_c3", {8'd0, c3_sd}, 16'h005A);
    check_val("showr.sv_c4", {15'd0, c4_sv}, 16'd0);
    check_val("showr.sd_c4", {8'd0, c4_sd}, 16'h005A);
`else
    check_txn("showr", 8'h5A, 8'h5A, 5'b00000, 1'b1, 4'b0000);
    check_val("showr.sv_c3", {15'd0, c3_sv}, 16'd0);
    check_val("showr.sd_c3", {8'd0, c3_sd}, 16'd0);
`endif

    // Reset during EXEC of ADD rd=4
    instr_valid = 1'b1; instr_op = 5'b00001; instr_rd = 3'd4; instr_rs = 3'd5; instr_im = 3'd0;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_val("mid.op_exec", {11'd0, alu_op}, 16'h0001);
    reset = 1'b1;
    @(negedge clock);
    check_val("mid.done", {15'd0, done}, 16'd0);
    check_val("mid.ready", {15'd0, instr_ready}, 16'd1);
    check_val("mid.alu_op", {11'd0, alu_op}, 16'd0);
    check_val("mid.flags", {12'd0, flags}, 16'd0);
    check_val("mid.in1", {8'd0, alu_in1}, 16'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_val("mid.no_done", {15'd0, done}, 16'd0);
    end
    issue(5'b00000, 3'd4, 3'd1, 3'd0, 1'b0);   // NOP reads R4 and R1 back at reset value
    check_txn("post_rst", 8'h05, 8'h05, 5'b00000, 1'b0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
